// File: rtl/div_unit.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle, sign fix on the final edge.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             annul_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             ready_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] orig;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic             ready_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rmd_q;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;

    // Operand magnitudes and request acceptance.
    always_comb begin
        accept = (state == IDLE) && start_i && !annul_i;
        last   = (cnt == LAST);
        a_mag  = dividend_i;
        b_mag  = divisor_i;
        if (signed_i && dividend_i[WIDTH-1]) begin
            a_mag = -dividend_i;
        end
        if (signed_i && divisor_i[WIDTH-1]) begin
            b_mag = -divisor_i;
        end
    end

    // One restoring step: shift in the next dividend bit, try the subtract.
    always_comb begin
        shifted = {rem, dvd[WIDTH-1]};
        trial   = shifted - {1'b0, dsr};
        fits    = !trial[WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; annul wins over start and completion.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_next = IDLE;
                end else if (dz || last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (annul_i || !start_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands, iterate, then sign-fix into the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            rem    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            orig   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            quot_q <= '0;
            rmd_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        orig  <= dividend_i;
                        neg_q <= signed_i
                                 && (dividend_i[WIDTH-1]
                                     ^ divisor_i[WIDTH-1]);
                        neg_r <= signed_i && dividend_i[WIDTH-1];
                        dz    <= (divisor_i == '0);
                        dvd   <= a_mag;
                        dsr   <= b_mag;
                        rem   <= '0;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    if (!annul_i) begin
                        if (dz) begin
                            quot_q <= '1;
                            rmd_q  <= orig;
                        end else if (last) begin
                            quot_q <= neg_q ? -dvd : dvd;
                            rmd_q  <= neg_r ? -rem : rem;
                        end else begin
                            rem <= fits ? trial[WIDTH-1:0]
                                        : shifted[WIDTH-1:0];
                            dvd <= {dvd[WIDTH-2:0], fits};
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Result-valid flag, registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (state_next == DONE);
        end
    end

    assign ready_o     = ready_q;
    assign quotient_o  = quot_q;
    assign remainder_o = rmd_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed vectors, scoreboard queue,
// monitor pops on each rising ready_o.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        annul;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        ready;

    int total  = 0;
    int passed = 0;

    logic [63:0] exp_q[$];
    logic        ready_d = 1'b0;

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .annul_i     (annul),
        .signed_i    (sgn),
        .dividend_i  (a),
        .divisor_i   (b),
        .quotient_o  (q),
        .remainder_o (r),
        .ready_o     (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act === req) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: compare each delivered result with the oldest expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (ready && !ready_d) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_result: got q=%h r=%h want none",
                         q, r);
            end else begin
                e = exp_q.pop_front();
                check("quotient", q, e[63:32]);
                check("remainder", r, e[31:0]);
            end
        end
        ready_d = ready;
    end

    task automatic op(input logic s, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] eq,
                      input logic [31:0] er, input int lat,
                      input bit scr, input bit hold);
        int n;
        n = 0;
        @(negedge clk);
        sgn   = s;
        a     = x;
        b     = y;
        start = 1'b1;
        exp_q.push_back({eq, er});
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (scr && n == 1) begin
                a   = 32'hDEADBEEF;
                b   = 32'h00000003;
                sgn = ~s;
            end
        end while (!ready && n < 100);
        check("latency", 32'(n), 32'(lat));
        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_ready", {31'b0, ready}, 32'd1);
            check("hold_quotient", q, eq);
            check("hold_remainder", r, er);
        end
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_drop", {31'b0, ready}, 32'd0);
    endtask

    initial begin
        int hi;
        rst   = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        sgn   = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'b0, ready}, 32'd0);
        check("reset_quotient", q, 32'd0);
        check("reset_remainder", r, 32'd0);
        rst = 1'b0;

        op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0, 1'b1);
        op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF,
           34, 1'b0, 1'b0);
        op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,
           34, 1'b0, 1'b0);
        op(1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1,
           34, 1'b0, 1'b0);
        op(1'b1, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678,
           2, 1'b0, 1'b0);
        op(1'b0, 32'h12345678, 32'd0, 32'hFFFFFFFF, 32'h12345678,
           2, 1'b0, 1'b0);
        op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,
           34, 1'b0, 1'b0);
        op(1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0,
           34, 1'b0, 1'b0);
        op(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 34, 1'b1, 1'b0);

        // Annul mid-operation: no result may appear.
        @(negedge clk);
        sgn   = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        repeat (11) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        annul = 1'b0;
        check("annul_ready", {31'b0, ready}, 32'd0);
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) hi++;
        end
        check("annul_no_ready", 32'(hi), 32'd0);
        op(1'b0, 32'd20, 32'd3, 32'd6, 32'd2, 34, 1'b0, 1'b0);

        // start drops during BUSY: result pulses for exactly one cycle.
        @(negedge clk);
        sgn   = 1'b1;
        a     = 32'd50;
        b     = 32'd5;
        start = 1'b1;
        exp_q.push_back({32'd10, 32'd0});
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        hi = 0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (ready) hi++;
        end
        check("pulse_width", 32'(hi), 32'd1);

        // Reset mid-BUSY clears everything at that edge.
        @(negedge clk);
        sgn   = 1'b0;
        a     = 32'd77;
        b     = 32'd5;
        start = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_quotient", q, 32'd0);
        check("rst_remainder", r, 32'd0);
        rst = 1'b0;
        hi = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) hi++;
        end
        check("rst_no_ready", 32'(hi), 32'd0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
